// File: rtl/phy_tx_monitor_if.sv
// Nibble-stream monitor bus: transmit nibble stream in, reassembled bytes,
// per-frame status and frame counters out.
interface phy_tx_monitor_if;
  logic [3:0]  phy_data_out;
  logic        phy_tx_en;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_frame_done;
  logic [11:0] rx_frame_len;
  logic [15:0] rx_frame_sum;
  logic        rx_frame_ok;
  logic        rx_err_align;
  logic        rx_err_runt;
  logic        rx_err_giant;
  logic        rx_err_ifg;
  logic [15:0] good_count;
  logic [15:0] bad_count;

  // Transmit side: drives the nibble stream, observes the monitor results.
  modport master (
    output phy_data_out, phy_tx_en,
    input  rx_byte, rx_byte_valid, rx_frame_done, rx_frame_len, rx_frame_sum,
    input  rx_frame_ok, rx_err_align, rx_err_runt, rx_err_giant, rx_err_ifg,
    input  good_count, bad_count
  );

  // Monitor side.
  modport slave (
    input  phy_data_out, phy_tx_en,
    output rx_byte, rx_byte_valid, rx_frame_done, rx_frame_len, rx_frame_sum,
    output rx_frame_ok, rx_err_align, rx_err_runt, rx_err_giant, rx_err_ifg,
    output good_count, bad_count
  );
endinterface

// File: rtl/phy_tx_monitor.sv
// Receive-side monitor for the xmitTop nibble stream. Reassembles bytes low
// nibble first, delimits frames on phy_tx_en, and reports per-frame length,
// byte sum and error flags plus good/bad frame counters.
module phy_tx_monitor #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2047,
  parameter int MIN_IFG = 24
) (
  input  logic              clk_phy,
  input  logic              reset,
  phy_tx_monitor_if.slave   bus
);

  localparam int                GAP_W   = $clog2(MIN_IFG + 1);
  localparam logic [GAP_W-1:0]  GAP_MAX = GAP_W'(MIN_IFG);
  localparam logic [GAP_W-1:0]  GAP_ONE = GAP_W'(1);
  localparam logic [11:0]       LEN_SAT = 12'hFFF;

  typedef enum logic [1:0] {IDLE, LO, HI, DROP} state_t;

  state_t           state, state_nxt;
  logic             post_reset;   // high only in the first cycle after reset release
  logic             start_frame, capture_lo, take_byte, end_frame, end_align, drop_exit;

  logic [3:0]       lo_nib;
  logic [11:0]      len_acc;
  logic [15:0]      sum_acc;
  logic             ifg_bad;
  logic [GAP_W-1:0] gap;

  logic [7:0]       byte_now;
  logic [11:0]      len_inc;
  logic             runt_now, giant_now, ok_now;

  assign byte_now  = {bus.phy_data_out, lo_nib};
  assign len_inc   = (len_acc == LEN_SAT) ? len_acc : len_acc + 12'd1;
  assign runt_now  = len_acc < 12'(MIN_LEN);
  assign giant_now = len_acc > 12'(MAX_LEN);
  assign ok_now    = !(runt_now || giant_now || end_align || ifg_bad);

  // State register; post_reset lets IDLE divert a frame already in flight to DROP.
  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      post_reset <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of block ordering.
      state      <= state_nxt;
      post_reset <= 1'b0;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    state_nxt   = state;
    start_frame = 1'b0;
    capture_lo  = 1'b0;
    take_byte   = 1'b0;
    end_frame   = 1'b0;
    end_align   = 1'b0;
    drop_exit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.phy_tx_en) begin
          if (post_reset) begin
            state_nxt = DROP;
          end else begin
            start_frame = 1'b1;
            capture_lo  = 1'b1;
            state_nxt   = HI;
          end
        end
      end
      HI: begin
        if (bus.phy_tx_en) begin
          take_byte = 1'b1;
          state_nxt = LO;
        end else begin
          end_frame = 1'b1;
          end_align = 1'b1;
          state_nxt = IDLE;
        end
      end
      LO: begin
        if (bus.phy_tx_en) begin
          capture_lo = 1'b1;
          state_nxt  = HI;
        end else begin
          end_frame = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!bus.phy_tx_en) begin
          drop_exit = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame accumulators and inter-frame gap counter.
  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      lo_nib  <= '0;
      len_acc <= '0;
      sum_acc <= '0;
      ifg_bad <= 1'b0;
      gap     <= GAP_MAX;
    end else begin
      if (start_frame) begin
        len_acc <= '0;
        sum_acc <= '0;
        ifg_bad <= (gap < GAP_MAX);
      end
      if (capture_lo) lo_nib <= bus.phy_data_out;
      if (take_byte) begin
        len_acc <= len_inc;
        sum_acc <= sum_acc + {8'h00, byte_now};
      end
      if (end_frame || drop_exit) begin
        gap <= GAP_ONE;
      end else if (state == IDLE && !bus.phy_tx_en && gap < GAP_MAX) begin
        gap <= gap + GAP_ONE;
      end
    end
  end

  // Byte strobe, end-of-frame status and frame counters.
  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      bus.rx_byte       <= '0;
      bus.rx_byte_valid <= 1'b0;
      bus.rx_frame_done <= 1'b0;
      bus.rx_frame_len  <= '0;
      bus.rx_frame_sum  <= '0;
      bus.rx_frame_ok   <= 1'b0;
      bus.rx_err_align  <= 1'b0;
      bus.rx_err_runt   <= 1'b0;
      bus.rx_err_giant  <= 1'b0;
      bus.rx_err_ifg    <= 1'b0;
      bus.good_count    <= '0;
      bus.bad_count     <= '0;
    end else begin
      bus.rx_byte_valid <= take_byte;
      bus.rx_frame_done <= end_frame;
      if (take_byte) bus.rx_byte <= byte_now;
      if (end_frame) begin
        bus.rx_frame_len <= len_acc;
        bus.rx_frame_sum <= sum_acc;
        bus.rx_frame_ok  <= ok_now;
        bus.rx_err_align <= end_align;
        bus.rx_err_runt  <= runt_now;
        bus.rx_err_giant <= giant_now;
        bus.rx_err_ifg   <= ifg_bad;
        if (ok_now) bus.good_count <= bus.good_count + 16'd1;
        else        bus.bad_count  <= bus.bad_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_monitor.sv
// Self-checking bench for phy_tx_monitor. Frames are built as nibble lists;
// a frame-level model derives the expected bytes, status, strobe cycles and
// counters from the nibble list and the idle gap preceding it.
module tb_phy_tx_monitor;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 2047;
  localparam int MIN_IFG = 24;

  logic        clk_phy = 1'b0;
  logic        reset;
  int unsigned cyc = 0;

  phy_tx_monitor_if bus ();

  phy_tx_monitor #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .MIN_IFG (MIN_IFG)
  ) dut (
    .clk_phy (clk_phy),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_phy = ~clk_phy;
  always @(posedge clk_phy) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] len;
    logic [15:0] sum;
    logic        align, runt, giant, ifg, ok;
    logic [15:0] good, bad;
    int unsigned cyc;
  } frame_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } byte_t;

  frame_t     exp_frames[$];
  byte_t      exp_bytes[$];
  logic [3:0] nib_q[$];

  int checks = 0;
  int errors = 0;
  bit fresh;
  int model_good, model_bad;
  int byte_strobes;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: bytes are nibble pairs (low first), length
  // saturates, flags follow the length/gap/nibble-parity rules.
  task automatic push_model(input int gap, input int unsigned c0, input int byte_limit,
                            input bit add_frame);
    int          n, nbytes;
    logic [15:0] s;
    logic [7:0]  bv;
    byte_t       b;
    frame_t      f;
    n      = nib_q.size();
    nbytes = n / 2;
    s      = '0;
    for (int k = 0; k < nbytes; k++) begin
      bv = {nib_q[2*k+1], nib_q[2*k]};
      s  = s + 16'(bv);
      if (k < byte_limit) begin
        b.data = bv;
        b.cyc  = c0 + 32'(2*k + 2);
        exp_bytes.push_back(b);
      end
    end
    if (add_frame) begin
      f.len   = (nbytes > 4095) ? 12'd4095 : 12'(nbytes);
      f.sum   = s;
      f.align = (n % 2) != 0;
      f.runt  = f.len < 12'(MIN_LEN);
      f.giant = f.len > 12'(MAX_LEN);
      f.ifg   = !fresh && (gap < MIN_IFG);
      f.ok    = !(f.align || f.runt || f.giant || f.ifg);
      if (f.ok) model_good++;
      else      model_bad++;
      f.good  = 16'(model_good);
      f.bad   = 16'(model_bad);
      f.cyc   = c0 + 32'(n + 1);
      exp_frames.push_back(f);
      fresh = 1'b0;
    end
  endtask

  task automatic build_random(input int n);
    nib_q.delete();
    repeat (n) nib_q.push_back(4'($urandom_range(0, 15)));
  endtask

  task automatic push_byte(input logic [7:0] v);
    nib_q.push_back(v[3:0]);
    nib_q.push_back(v[7:4]);
  endtask

  // Drives gap idle samples (counted from the first low sample after the
  // previous frame), then the nibble list, then returns with tx_en low.
  task automatic send_frame(input int gap);
    if (gap > 1) repeat (gap - 1) @(negedge clk_phy);
    @(negedge clk_phy);
    push_model(gap, cyc, 1 << 30, 1'b1);
    for (int i = 0; i < nib_q.size(); i++) begin
      if (i > 0) @(negedge clk_phy);
      bus.phy_tx_en    = 1'b1;
      bus.phy_data_out = nib_q[i];
    end
    @(negedge clk_phy);
    bus.phy_tx_en    = 1'b0;
    bus.phy_data_out = 4'($urandom_range(0, 15));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_status"},
          {bus.rx_frame_len, bus.rx_frame_sum, bus.rx_frame_ok, bus.rx_err_align,
           bus.rx_err_runt, bus.rx_err_giant, bus.rx_err_ifg, bus.rx_byte,
           bus.rx_byte_valid, bus.rx_frame_done}, 64'd0);
    check({tag, "_counts"}, {bus.good_count, bus.bad_count}, 64'd0);
  endtask

  // Frame cut by reset after byte 99; the tail is driven with tx_en still high.
  task automatic send_reset_frame();
    repeat (39) @(negedge clk_phy);
    build_random(256);
    @(negedge clk_phy);
    push_model(40, cyc, 100, 1'b0);
    for (int i = 0; i < nib_q.size(); i++) begin
      if (i > 0) @(negedge clk_phy);
      bus.phy_tx_en    = 1'b1;
      bus.phy_data_out = nib_q[i];
      if (i == 200) begin
        #2 reset = 1'b0;
      end
      if (i == 203) check_reset_outputs("midframe_reset");
      if (i == 205) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clk_phy);
    bus.phy_tx_en = 1'b0;
    fresh      = 1'b0;
    model_good = 0;
    model_bad  = 0;
  endtask

  byte_t  mon_b;
  frame_t mon_f;

  // Output monitor: every strobe must match the head of the expected queues.
  always @(negedge clk_phy) begin
    if (reset) begin
      if (bus.rx_byte_valid) begin
        byte_strobes++;
        if (exp_bytes.size() == 0) begin
          check("unexpected_byte", 64'd1, 64'd0);
        end else begin
          mon_b = exp_bytes.pop_front();
          check("byte_data", bus.rx_byte, mon_b.data);
          check("byte_cycle", cyc, mon_b.cyc);
        end
      end
      if (bus.rx_frame_done) begin
        if (exp_frames.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_f = exp_frames.pop_front();
          check("done_cycle", cyc, mon_f.cyc);
          check("frame_len", bus.rx_frame_len, mon_f.len);
          check("frame_sum", bus.rx_frame_sum, mon_f.sum);
          check("frame_ok", bus.rx_frame_ok, mon_f.ok);
          check("err_align", bus.rx_err_align, mon_f.align);
          check("err_runt", bus.rx_err_runt, mon_f.runt);
          check("err_giant", bus.rx_err_giant, mon_f.giant);
          check("err_ifg", bus.rx_err_ifg, mon_f.ifg);
          check("good_count", bus.good_count, mon_f.good);
          check("bad_count", bus.bad_count, mon_f.bad);
        end
      end
    end
  end

  task automatic settle();
    repeat (2) @(negedge clk_phy);
  endtask

  initial begin
    reset            = 1'b0;
    bus.phy_tx_en    = 1'b0;
    bus.phy_data_out = 4'd0;
    fresh            = 1'b1;
    model_good       = 0;
    model_bad        = 0;
    byte_strobes     = 0;
    repeat (3) @(negedge clk_phy);
    check_reset_outputs("reset_state");
    reset = 1'b1;

    // Single 512-byte frame: FF x4, 00 x504, FF x4.
    nib_q.delete();
    repeat (4)   push_byte(8'hFF);
    repeat (504) push_byte(8'h00);
    repeat (4)   push_byte(8'hFF);
    send_frame(40);
    settle();
    check("t1_len", bus.rx_frame_len, 64'd512);
    check("t1_sum", bus.rx_frame_sum, 64'h07F8);
    check("t1_ok", bus.rx_frame_ok, 64'd1);
    check("t1_good", bus.good_count, 64'd1);
    check("t1_strobes", 64'(byte_strobes), 64'd512);

    // 64 frames separated by exactly MIN_IFG idle cycles.
    for (int f = 0; f < 64; f++) begin
      build_random(2 * int'($urandom_range(64, 128)));
      send_frame(MIN_IFG);
    end
    settle();
    check("t2_good", bus.good_count, 64'd65);
    check("t2_bad", bus.bad_count, 64'd0);

    // 64 bytes plus one trailing low nibble.
    build_random(129);
    send_frame(30);
    settle();
    check("t3_len", bus.rx_frame_len, 64'd64);
    check("t3_align", bus.rx_err_align, 64'd1);
    check("t3_ok", bus.rx_frame_ok, 64'd0);
    check("t3_bad", bus.bad_count, 64'd1);

    // Runt, then a frame overflowing the length counter.
    build_random(64);
    send_frame(30);
    settle();
    check("t4_runt", bus.rx_err_runt, 64'd1);
    build_random(2 * (4096 + 8));
    send_frame(30);
    settle();
    check("t4_len", bus.rx_frame_len, 64'd4095);
    check("t4_giant", bus.rx_err_giant, 64'd1);
    check("t4_bad", bus.bad_count, 64'd3);

    // Short gaps of 10 and 1 cycles.
    for (int p = 0; p < 2; p++) begin
      build_random(128);
      send_frame(30);
      build_random(128);
      send_frame((p == 0) ? 10 : 1);
      settle();
      check("t5_ifg", bus.rx_err_ifg, 64'd1);
      check("t5_len", bus.rx_frame_len, 64'd64);
    end

    // Random lengths (odd and even nibble counts) and random gaps.
    for (int f = 0; f < 20; f++) begin
      build_random(int'($urandom_range(2, 300)));
      send_frame(int'($urandom_range(1, 40)));
    end

    // Reset mid-frame, then a well-spaced 64-byte frame.
    send_reset_frame();
    build_random(128);
    send_frame(40);
    settle();
    check("t6_ok", bus.rx_frame_ok, 64'd1);
    check("t6_good", bus.good_count, 64'd1);
    check("t6_bad", bus.bad_count, 64'd0);

    repeat (5) @(negedge clk_phy);
    check("pending_bytes", 64'(exp_bytes.size()), 64'd0);
    check("pending_frames", 64'(exp_frames.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
